// File: rtl/pulse_sync_hs_pkg.sv
// Shared definitions for the handshake pulse synchronizer: source FSM states
// and the default synchronizer depth.
package pulse_sync_hs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/pulse_sync_hs_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
module pulse_sync_hs_sync_bit
  import pulse_sync_hs_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pulse_sync_hs.sv
// Handshake pulse synchronizer: clka pulses are queued and delivered one at a
// time to clkb over a 4-phase req/ack handshake, so any clock ratio works.
module pulse_sync_hs
  import pulse_sync_hs_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic             clka,
  input  logic             clkb,
  input  logic             rst_n,
  input  logic             sig_a,
  input  logic             clr_ovf_a,
  output logic             sig_b,
  output logic             busy_a,
  output logic [CNT_W-1:0] pend_cnt_a,
  output logic             ovf_a
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_req_a;
  logic             w_req_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             w_cnt_zero;
  logic             w_inc;
  logic             w_dec;
  logic             w_drop;
  logic             w_ack_sync;
  logic             w_req_s;
  logic             r_req_d;

  assign w_cnt_zero = (r_cnt == '0);

  // A pulse in IDLE with an empty queue launches directly; any other pulse queues.
  assign w_inc  = sig_a & ~((r_state == IDLE) & w_cnt_zero);
  assign w_dec  = (r_state == IDLE) & ~w_cnt_zero;
  assign w_drop = w_inc & ~w_dec & (r_cnt == CNT_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req_a;
    unique case (r_state)
      IDLE: begin
        w_req_nxt = 1'b0;
        if (sig_a || !w_cnt_zero) begin
          w_state_nxt = REQ;
          w_req_nxt   = 1'b1;
        end
      end
      REQ: begin
        w_req_nxt = 1'b1;
        if (w_ack_sync) begin
          w_state_nxt = RELEASE;
          w_req_nxt   = 1'b0;
        end
      end
      RELEASE: begin
        w_req_nxt = 1'b0;
        if (!w_ack_sync) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_inc && !w_dec && !w_drop) w_cnt_nxt = r_cnt + 1'b1;
    else if (w_dec && !w_inc)       w_cnt_nxt = r_cnt - 1'b1;
  end

  // A drop in the same cycle as a clear leaves the flag set.
  assign w_ovf_nxt = w_drop | (r_ovf & ~clr_ovf_a);

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req_a <= 1'b0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req_a <= w_req_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  pulse_sync_hs_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
    .i_clk   (clkb),
    .i_rst_n (rst_n),
    .i_d     (r_req_a),
    .o_q     (w_req_s)
  );

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) r_req_d <= 1'b0;
    else        r_req_d <= w_req_s;
  end

  pulse_sync_hs_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ack (
    .i_clk   (clka),
    .i_rst_n (rst_n),
    .i_d     (w_req_s),
    .o_q     (w_ack_sync)
  );

  assign sig_b      = w_req_s & ~r_req_d;
  assign busy_a     = (r_state != IDLE) | ~w_cnt_zero;
  assign pend_cnt_a = r_cnt;
  assign ovf_a      = r_ovf;

endmodule

// File: tb/tb_pulse_sync_hs.sv
// Directed and randomized bench for pulse_sync_hs with an event-count model.
module tb_pulse_sync_hs;
  import pulse_sync_hs_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 3;
  localparam int QMAX        = (1 << CNT_W) - 1;

  logic             clka = 1'b0;
  logic             clkb = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig_a = 1'b0;
  logic             clr_ovf_a = 1'b0;
  logic             sig_b;
  logic             busy_a;
  logic [CNT_W-1:0] pend_cnt_a;
  logic             ovf_a;

  int ha = 5;
  int hb = 20;
  int n_assert = 0;
  int n_fail = 0;
  int sigb_cnt = 0;
  logic sigb_prev = 1'b0;
  int pend_trace[$];

  always #(ha) clka = ~clka;
  always #(hb) clkb = ~clkb;

  pulse_sync_hs #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
    .clka       (clka),
    .clkb       (clkb),
    .rst_n      (rst_n),
    .sig_a      (sig_a),
    .clr_ovf_a  (clr_ovf_a),
    .sig_b      (sig_b),
    .busy_a     (busy_a),
    .pend_cnt_a (pend_cnt_a),
    .ovf_a      (ovf_a)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected queue depth and drop count after n back-to-back pulses from idle.
  function automatic int model_pend(input int n);
    return (n - 1 > QMAX) ? QMAX : n - 1;
  endfunction

  function automatic int model_drops(input int n);
    return (n - 1 > QMAX) ? n - 1 - QMAX : 0;
  endfunction

  always @(negedge clkb) begin
    if (!rst_n) begin
      sigb_prev = 1'b0;
    end else begin
      if (sig_b === 1'b1) begin
        sigb_cnt++;
        chk("sigb_width", 32'(sigb_prev), 0);
      end
      sigb_prev = sig_b;
    end
  end

  task automatic burst(input int n);
    for (int i = 0; i < n; i++) begin
      sig_a = 1'b1;
      @(negedge clka);
    end
    sig_a = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    int last;
    done = 1'b0;
    pend_trace.delete();
    last = int'(pend_cnt_a);
    for (int k = 0; k < 4000 && !done; k++) begin
      @(negedge clka);
      if (int'(pend_cnt_a) != last) begin
        last = int'(pend_cnt_a);
        pend_trace.push_back(last);
      end
      if (busy_a === 1'b0) done = 1'b1;
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
    repeat (3) @(negedge clkb);
    @(negedge clka);
  endtask

  initial begin
    int base;
    int n;
    bit found;

    // Reset state
    repeat (3) @(negedge clka);
    chk("rst_sig_b", 32'(sig_b), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_pend", 32'(pend_cnt_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clka);

    // Single pulse, fast source / slow destination
    base = sigb_cnt;
    sig_a = 1'b1;
    @(negedge clka);
    sig_a = 1'b0;
    chk("single_req", 32'(dut.r_req_a), 1);
    chk("single_busy", 32'(busy_a), 1);
    chk("single_pend", 32'(pend_cnt_a), 0);
    wait_idle("single");
    chk("single_trace", pend_trace.size(), 0);
    chk("single_sigb", sigb_cnt - base, 1);
    chk("single_idle", 32'(busy_a), 0);

    // Five back-to-back pulses: queue fills to 4 then drains one per launch
    base = sigb_cnt;
    burst(5);
    chk("burst5_pend", 32'(pend_cnt_a), model_pend(5));
    wait_idle("burst5");
    chk("burst5_trace_len", pend_trace.size(), 4);
    for (int i = 0; i < pend_trace.size() && i < 4; i++)
      chk("burst5_trace", pend_trace[i], 3 - i);
    chk("burst5_sigb", sigb_cnt - base, 5);
    chk("burst5_ovf", 32'(ovf_a), 0);

    // Overflow: queue saturates, extra pulses dropped, set beats clear
    base = sigb_cnt;
    burst(10);
    chk("ovf_pend", 32'(pend_cnt_a), model_pend(10));
    chk("ovf_flag", 32'(ovf_a), (model_drops(10) > 0) ? 1 : 0);
    sig_a = 1'b1;
    clr_ovf_a = 1'b1;
    @(negedge clka);
    sig_a = 1'b0;
    chk("ovf_set_wins", 32'(ovf_a), 1);
    chk("ovf_pend_hold", 32'(pend_cnt_a), QMAX);
    @(negedge clka);
    clr_ovf_a = 1'b0;
    chk("ovf_cleared", 32'(ovf_a), 0);
    wait_idle("ovf");
    chk("ovf_sigb", sigb_cnt - base, 1 + QMAX);

    // Reset in the middle of a transfer with pulses queued
    burst(4);
    chk("midrst_pend", 32'(pend_cnt_a), 3);
    chk("midrst_busy", 32'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_sig_b", 32'(sig_b), 0);
    chk("midrst_busy0", 32'(busy_a), 0);
    chk("midrst_pend0", 32'(pend_cnt_a), 0);
    chk("midrst_ovf0", 32'(ovf_a), 0);
    repeat (3) @(negedge clka);
    rst_n = 1'b1;
    base = sigb_cnt;
    repeat (50) @(negedge clkb);
    @(negedge clka);
    chk("midrst_no_sigb", sigb_cnt - base, 0);
    chk("midrst_idle", 32'(busy_a), 0);

    // New pulse on the same edge a queued pulse launches
    base = sigb_cnt;
    burst(2);
    chk("coinc_pend1", 32'(pend_cnt_a), 1);
    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      if (dut.r_state == IDLE) found = 1'b1;
      else @(negedge clka);
    end
    if (!found) chk("coinc_timeout", 0, 1);
    sig_a = 1'b1;
    @(negedge clka);
    sig_a = 1'b0;
    chk("coinc_pend_net0", 32'(pend_cnt_a), 1);
    chk("coinc_busy", 32'(busy_a), 1);
    wait_idle("coinc");
    chk("coinc_sigb", sigb_cnt - base, 3);

    // Slow source, fast destination
    ha = 20;
    hb = 5;
    repeat (4) @(negedge clka);
    base = sigb_cnt;
    for (int i = 0; i < 3; i++) begin
      sig_a = 1'b1;
      @(negedge clka);
      sig_a = 1'b0;
      @(negedge clka);
    end
    wait_idle("slowfast");
    chk("slowfast_sigb", sigb_cnt - base, 3);
    chk("slowfast_ovf", 32'(ovf_a), 0);

    // Random ratios and spacing, never more pulses than the queue can absorb
    for (int r = 0; r < 8; r++) begin
      ha = int'($urandom_range(3, 25));
      hb = int'($urandom_range(3, 25));
      repeat (3) @(negedge clka);
      base = sigb_cnt;
      n = int'($urandom_range(1, QMAX + 1));
      for (int i = 0; i < n; i++) begin
        sig_a = 1'b1;
        @(negedge clka);
        sig_a = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clka);
      end
      wait_idle("rand");
      chk("rand_sigb", sigb_cnt - base, n);
      chk("rand_pend", 32'(pend_cnt_a), 0);
      chk("rand_ovf", 32'(ovf_a), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_sync_hs.md
Name: pulse_sync_hs

Overview:
- Handshake pulse synchronizer. Carries single-cycle pulses from the clka domain to the clkb domain for any frequency ratio.
- Uses a 4-phase req/ack handshake, so it needs no ratio constraint. Pulses arriving while a transfer is in flight are counted and replayed, so none are lost.
- Sits at any clka→clkb control boundary that needs guaranteed delivery and a source-side busy indication.

Parameters:
- SYNC_STAGES, 2, flop count of each synchronizer chain (req into clkb, ack into clka); legal range ≥2.
- CNT_W, 4, width of the pending-pulse counter; maximum queued pulses = 2^CNT_W-1.

Ports:
- clka  in  1  source clock.
- clkb  in  1  destination clock.
- rst_n  in  1  reset, asynchronous, active-low; clock clka. The same net resets the clkb flops. Deassertion is synchronized per domain by the top-level reset tree.
- sig_a  in  1  clka pulse; every high cycle is one event.
- clr_ovf_a  in  1  clka; clears ovf_a.
- sig_b  out  1  clkb pulse, high exactly one clkb cycle per delivered event.
- busy_a  out  1  clka; high while a transfer is in flight or pulses are pending.
- pend_cnt_a  out  CNT_W  clka; queued pulses not yet launched.
- ovf_a  out  1  clka; sticky, set when a pulse is dropped.

Behaviour:
- Reset: every flop in both domains is 0. Resulting outputs: sig_b=0, busy_a=0, pend_cnt_a=0, ovf_a=0, source FSM in IDLE.
- Source FSM (clka):
  - States: IDLE, REQ, RELEASE.
  - IDLE→REQ when sig_a=1 and cnt=0 (direct launch; counter untouched), or when cnt>0 (launch; cnt decrements). Launch sets req_a=1 on that edge.
  - REQ: hold req_a=1. Go to RELEASE when ack_sync=1; req_a←0.
  - RELEASE: hold req_a=0. Go to IDLE when ack_sync=0.
- Counter rules:
  - sig_a=1 while in REQ or RELEASE, or in IDLE with cnt>0 while launching: cnt+1.
  - sig_a and a launch decrement in the same cycle: net 0.
  - At cnt=2^CNT_W-1, an incoming sig_a that would increment is dropped and ovf_a←1.
  - clr_ovf_a together with a new overflow: set wins.
- Destination (clkb):
  - req_a passes through SYNC_STAGES flops to req_s.
  - One further flop gives req_d.
  - sig_b = req_s & ~req_d, decoded from flops only, never from the raw input.
  - ack_b = req_s returns through SYNC_STAGES clka flops to ack_sync.
- Latency:
  - req_a rises on the first clka edge sampling sig_a=1 (IDLE, cnt=0).
  - sig_b rises SYNC_STAGES clkb edges after req_a, ±1 clkb cycle for metastability.
  - Full cycle ≈ 2·SYNC_STAGES clkb + 2·SYNC_STAGES clka + 2 clka cycles. Sustained throughput is one pulse per full cycle.
- busy_a = (state≠IDLE) | (cnt≠0).
- Exactly one sig_b per accepted sig_a cycle, in order. Dropped pulses produce no sig_b.
- Reset mid-transfer clears both sides. Queued pulses are discarded. No sig_b is produced after reset release unless a new sig_a arrives.
- Consecutive sig_a cycles count as separate events.

Decomposition:
- Shared package: FSM state enum (IDLE/REQ/RELEASE) and the default SYNC_STAGES constant.
- One sub-module, sync_bit: a parameterized SYNC_STAGES-deep single-bit synchronizer with async reset. It is instantiated twice, once for req and once for ack.

Test Plan:
- clka 100 MHz, clkb 25 MHz, single sig_a pulse → exactly one sig_b. req_a high 1 clka cycle after sig_a. busy_a returns to 0. pend_cnt_a stays 0.
- Same clocks, 5 sig_a pulses on consecutive clka cycles → pend_cnt_a peaks at 4 and counts down 4,3,2,1,0 per launch. Exactly 5 sig_b pulses. ovf_a=0.
- CNT_W=2, 6 consecutive sig_a pulses → first launched, 3 queued, 2 dropped. 4 sig_b pulses. ovf_a=1 until clr_ovf_a; clr_ovf_a in the same cycle as a new drop leaves ovf_a=1.
- clka 25 MHz, clkb 100 MHz (slow→fast), 3 pulses spaced 2 clka apart → 3 sig_b pulses, each 1 clkb wide.
- Assert rst_n while in REQ with pend_cnt_a=3, then release → all outputs 0. No sig_b for 50 clkb cycles after release.
- sig_a arrives in IDLE on the same edge that a queued pulse launches (cnt=1) → cnt stays 1. Launch order is preserved. The total sig_b count equals the accepted sig_a count.
